exc_vector_seq: RTL and testbench

Exception-vector sequencer and owner of the memory-address select (IorD) for the multicycle MIPS datapath. When idle it passes the main control unit's IorD select and memory-read request straight through. On an exception it stalls the main control and takes over the select. It then saves EPC, reads the handler byte at the fixed vector address (253/254/255) and loads PC with the zero-extended handler address.

---
 rtl/exc_pkg.sv | 41 ++++
 rtl/exc_prio_enc.sv | 30 +++
 rtl/exc_vector_seq.sv | 153 +++++++++++++++
 tb/tb_exc_vector_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception-vector sequencer.
// Nested exception queuing is enabled by defining EXC_NEST_EN.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAVE = 3'd1,
    READ = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OPC  = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV  = 2'd3
  } cause_t;

  localparam logic [2:0] SEL_REGA    = 3'd0;
  localparam logic [2:0] SEL_PC      = 3'd1;
  localparam logic [2:0] SEL_ALUOUT  = 3'd2;
  localparam logic [2:0] SEL_VEC_OPC = 3'd3;
  localparam logic [2:0] SEL_VEC_OVF = 3'd4;
  localparam logic [2:0] SEL_VEC_DIV = 3'd5;

  localparam logic [7:0] VEC_ADDR_OPC = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVF = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV = 8'd255;

  // Request-vector bit owned by a cause: bit0 opcode, bit1 overflow, bit2 div0.
  function automatic logic [2:0] cause_to_bit(cause_t c);
    case (c)
      CAUSE_OPC: return 3'b001;
      CAUSE_OVF: return 3'b010;
      CAUSE_DIV: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: opcode > overflow > div0, yielding cause and vector select.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [2:0] req,
  output logic       valid,
  output cause_t     cause,
  output logic [2:0] sel
);

  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    valid = 1'b1;
    cause = CAUSE_NONE;
    sel   = SEL_REGA;
    if (req[0]) begin
      cause = CAUSE_OPC;
      sel   = SEL_VEC_OPC;
    end else if (req[1]) begin
      cause = CAUSE_OVF;
      sel   = SEL_VEC_OVF;
    end else if (req[2]) begin
      cause = CAUSE_DIV;
      sel   = SEL_VEC_DIV;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_vector_seq.sv
// Exception-vector sequencer owning the IorD select; SAVE -> READ -> LOAD -> DONE.
// Define EXC_NEST_EN to queue exceptions raised mid-sequence in a pending register.
module exc_vector_seq
  import exc_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        ctrl_iord,
  input  logic              ctrl_mem_rd,
  input  logic              exc_opcode,
  input  logic              exc_overflow,
  input  logic              exc_div0,
  input  logic [7:0]        mem_data,
  output logic [2:0]        iord_sel,
  output logic              mem_rd,
  output logic              epc_wr,
  output logic              pc_wr,
  output logic              pc_src_exc,
  output logic [ADDR_W-1:0] handler_pc,
  output logic [1:0]        cause,
  output logic              stall,
  output logic              exc_done
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

  state_t     state;
  cause_t     cause_q;
  logic [3:0] wait_cnt;
  logic [2:0] vec_sel_q;
  logic       mem_rd_q;

  logic [2:0] exc_vec;
  logic [2:0] req;
  logic       req_valid;
  cause_t     enc_cause;
  logic [2:0] enc_sel;

  assign exc_vec = {exc_div0, exc_overflow, exc_opcode};

`ifdef EXC_NEST_EN
  logic [2:0] pending;
  assign req = exc_vec | pending;

  // Exceptions raised mid-sequence accumulate; the one granted at DONE is retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 3'b000;
    end else begin
      case (state)
        SAVE, READ, LOAD: pending <= pending | exc_vec;
        DONE:             pending <= req & ~cause_to_bit(enc_cause);
        default:          pending <= 3'b000;
      endcase
    end
  end
`else
  assign req = exc_vec;
`endif

  exc_prio_enc u_prio_enc (
    .req   (req),
    .valid (req_valid),
    .cause (enc_cause),
    .sel   (enc_sel)
  );

  // Passthrough is combinational so main control sees its own select in IDLE.
  assign iord_sel = (state == IDLE) ? ctrl_iord   : vec_sel_q;
  assign mem_rd   = (state == IDLE) ? ctrl_mem_rd : mem_rd_q;
  assign cause    = cause_q;

  // NOTE: sequential state uses non-blocking assignments only; the pulse outputs
  // default low each cycle and are set for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cause_q    <= CAUSE_NONE;
      wait_cnt   <= 4'd0;
      vec_sel_q  <= SEL_REGA;
      mem_rd_q   <= 1'b0;
      handler_pc <= '0;
      stall      <= 1'b0;
      epc_wr     <= 1'b0;
      pc_wr      <= 1'b0;
      pc_src_exc <= 1'b0;
      exc_done   <= 1'b0;
    end else begin
      epc_wr     <= 1'b0;
      pc_wr      <= 1'b0;
      pc_src_exc <= 1'b0;
      exc_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SAVE;
            cause_q   <= enc_cause;
            vec_sel_q <= enc_sel;
            stall     <= 1'b1;
            epc_wr    <= 1'b1;
          end
        end
        SAVE: begin
          state    <= READ;
          mem_rd_q <= 1'b1;
          wait_cnt <= 4'd0;
        end
        READ: begin
          if (wait_cnt == LAST_CNT) begin
            handler_pc <= ADDR_W'(mem_data);
            state      <= LOAD;
            mem_rd_q   <= 1'b0;
            wait_cnt   <= 4'd0;
            pc_wr      <= 1'b1;
            pc_src_exc <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        LOAD: begin
          state    <= DONE;
          exc_done <= 1'b1;
        end
        DONE: begin
`ifdef EXC_NEST_EN
          if (req_valid) begin
            state     <= SAVE;
            cause_q   <= enc_cause;
            vec_sel_q <= enc_sel;
            epc_wr    <= 1'b1;
          end else begin
            state <= IDLE;
            stall <= 1'b0;
          end
`else
          state <= IDLE;
          stall <= 1'b0;
`endif
        end
        default: begin
          state    <= IDLE;
          stall    <= 1'b0;
          mem_rd_q <= 1'b0;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_vector_seq.sv
// Directed bench for exc_vector_seq: three instances (MEM_WAIT 2, 1, 15) share stimulus.
module tb_exc_vector_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] ctrl_iord = 3'd0;
  logic       ctrl_mem_rd = 1'b0;
  logic       exc_opcode = 1'b0;
  logic       exc_overflow = 1'b0;
  logic       exc_div0 = 1'b0;
  logic [7:0] mem_data = 8'd0;

  logic [2:0]  iord_sel, w1_iord_sel, w15_iord_sel;
  logic        mem_rd, w1_mem_rd, w15_mem_rd;
  logic        epc_wr, w1_epc_wr, w15_epc_wr;
  logic        pc_wr, w1_pc_wr, w15_pc_wr;
  logic        pc_src_exc, w1_pc_src_exc, w15_pc_src_exc;
  logic [31:0] handler_pc, w1_handler_pc, w15_handler_pc;
  logic [1:0]  cause, w1_cause, w15_cause;
  logic        stall, w1_stall, w15_stall;
  logic        exc_done, w1_exc_done, w15_exc_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_WAIT(2), .ADDR_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord), .ctrl_mem_rd(ctrl_mem_rd),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .mem_data(mem_data), .iord_sel(iord_sel), .mem_rd(mem_rd), .epc_wr(epc_wr),
    .pc_wr(pc_wr), .pc_src_exc(pc_src_exc), .handler_pc(handler_pc), .cause(cause),
    .stall(stall), .exc_done(exc_done)
  );

  exc_vector_seq #(.MEM_WAIT(1), .ADDR_W(32)) u_w1 (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord), .ctrl_mem_rd(ctrl_mem_rd),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .mem_data(mem_data), .iord_sel(w1_iord_sel), .mem_rd(w1_mem_rd), .epc_wr(w1_epc_wr),
    .pc_wr(w1_pc_wr), .pc_src_exc(w1_pc_src_exc), .handler_pc(w1_handler_pc),
    .cause(w1_cause), .stall(w1_stall), .exc_done(w1_exc_done)
  );

  exc_vector_seq #(.MEM_WAIT(15), .ADDR_W(32)) u_w15 (
    .clk(clk), .reset_n(reset_n), .ctrl_iord(ctrl_iord), .ctrl_mem_rd(ctrl_mem_rd),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .mem_data(mem_data), .iord_sel(w15_iord_sel), .mem_rd(w15_mem_rd), .epc_wr(w15_epc_wr),
    .pc_wr(w15_pc_wr), .pc_src_exc(w15_pc_src_exc), .handler_pc(w15_handler_pc),
    .cause(w15_cause), .stall(w15_stall), .exc_done(w15_exc_done)
  );

  task automatic test_reset();
    logic [8:0] got;
    @(negedge clk);
    reset_n     = 1'b0;
    ctrl_iord   = 3'd5;
    ctrl_mem_rd = 1'b1;
    #1;
    got = {stall, epc_wr, pc_wr, pc_src_exc, exc_done, mem_rd, iord_sel};
    checks++;
    if (got !== 9'b0_0000_1_101) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", got, 9'b0_0000_1_101);
    end
    checks++;
    if (handler_pc !== 32'd0 || cause !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: got handler_pc=%h cause=%0d expected 0/0", handler_pc, cause);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    ctrl_iord   = 3'd2;
    ctrl_mem_rd = 1'b1;
    #1;
    checks++;
    if ({iord_sel, mem_rd, stall} !== {3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL passthrough: got iord=%0d mem_rd=%b stall=%b expected 2/1/0",
               iord_sel, mem_rd, stall);
    end
  endtask

  // Exception at edge 0; ctrl_* held at 2/1 to show they are ignored while busy.
  task automatic test_overflow();
    logic [8:0] got, exp;
    @(negedge clk);
    exc_overflow = 1'b1;
    ctrl_iord    = 3'd2;
    ctrl_mem_rd  = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      exc_overflow = 1'b0;
      mem_data = (cyc == 3) ? 8'h9C : 8'h11;
      #1;
      case (cyc)
        1:       exp = 9'b1_1000_0_100;
        2, 3:    exp = 9'b1_0000_1_100;
        4:       exp = 9'b1_0110_0_100;
        5:       exp = 9'b1_0001_0_100;
        default: exp = 9'b0_0000_1_010;
      endcase
      got = {stall, epc_wr, pc_wr, pc_src_exc, exc_done, mem_rd, iord_sel};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overflow_cycle%0d: got %b expected %b", cyc, got, exp);
      end
      if (cyc == 1) begin
        checks++;
        if (cause !== 2'd2) begin
          errors++;
          $display("FAIL overflow_cause: got %0d expected 2", cause);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (handler_pc !== 32'd0) begin
          errors++;
          $display("FAIL overflow_hold: got %h expected 00000000", handler_pc);
        end
      end
      if (cyc >= 4) begin
        checks++;
        if (handler_pc !== 32'h0000009C) begin
          errors++;
          $display("FAIL overflow_handler_c%0d: got %h expected 0000009c", cyc, handler_pc);
        end
      end
    end
    checks++;
    if (cause !== 2'd2) begin
      errors++;
      $display("FAIL overflow_cause_held: got %0d expected 2", cause);
    end
  endtask

  task automatic test_reset_mid_read();
    int pc_seen = 0;
    ctrl_iord   = 3'd1;
    ctrl_mem_rd = 1'b0;
    exc_opcode  = 1'b1;
    @(negedge clk);
    exc_opcode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stall, iord_sel, mem_rd, epc_wr, pc_wr} !== {1'b0, 3'd1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midread_outputs: got stall=%b iord=%0d mem_rd=%b epc=%b pc=%b expected 0/1/0/0/0",
               stall, iord_sel, mem_rd, epc_wr, pc_wr);
    end
    checks++;
    if (cause !== 2'd0 || handler_pc !== 32'd0) begin
      errors++;
      $display("FAIL midread_regs: got cause=%0d handler_pc=%h expected 0/0", cause, handler_pc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_wr === 1'b1 || epc_wr === 1'b1) pc_seen++;
    end
    checks++;
    if (pc_seen != 0) begin
      errors++;
      $display("FAIL midread_no_pc_wr: got %0d pulses expected 0", pc_seen);
    end
  endtask

  task automatic test_priority();
    int epc_cnt = 0;
    test_reset();
    ctrl_iord = 3'd0;
    ctrl_mem_rd = 1'b0;
    @(negedge clk);
    exc_opcode = 1'b1;
    exc_div0   = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      exc_opcode = 1'b0;
      exc_div0   = 1'b0;
      #1;
      if (epc_wr === 1'b1) epc_cnt++;
      if (cyc == 1) begin
        checks++;
        if (cause !== 2'd1 || iord_sel !== 3'd3) begin
          errors++;
          $display("FAIL priority_sel: got cause=%0d iord=%0d expected 1/3", cause, iord_sel);
        end
      end
    end
    checks++;
    if (epc_cnt != 1 || stall !== 1'b0 || cause !== 2'd1) begin
      errors++;
      $display("FAIL priority_single: got epc=%0d stall=%b cause=%0d expected 1/0/1",
               epc_cnt, stall, cause);
    end
  endtask

  task automatic test_nest();
    int epc_cnt = 0;
    int pc_cnt = 0;
    logic [5:0] got, exp;
`ifdef EXC_NEST_EN
    exp = {1'b1, 2'd3, 3'd5};
`else
    exp = {1'b0, 2'd1, 3'd0};
`endif
    test_reset();
    ctrl_iord = 3'd0;
    ctrl_mem_rd = 1'b0;
    @(negedge clk);
    exc_opcode = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      exc_opcode = 1'b0;
      exc_div0   = (cyc == 2);
      #1;
      if (epc_wr === 1'b1) epc_cnt++;
      if (pc_wr === 1'b1) pc_cnt++;
      if (cyc == 6) begin
        got = {stall, cause, iord_sel};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL nest_second_start: got %b expected %b", got, exp);
        end
      end
    end
    checks++;
`ifdef EXC_NEST_EN
    if (epc_cnt != 2 || pc_cnt != 2) begin
      errors++;
      $display("FAIL nest_pulses: got epc=%0d pc=%0d expected 2/2", epc_cnt, pc_cnt);
    end
`else
    if (epc_cnt != 1 || pc_cnt != 1) begin
      errors++;
      $display("FAIL nest_pulses: got epc=%0d pc=%0d expected 1/1", epc_cnt, pc_cnt);
    end
`endif
  endtask

  // mem_data = 0x40 + cycle, so the captured byte identifies the last READ cycle.
  task automatic test_mem_wait_sweep();
    int rd1 = 0, rd2 = 0, rd15 = 0;
    int pc1 = 0, pc2 = 0, pc15 = 0;
    test_reset();
    ctrl_iord = 3'd0;
    ctrl_mem_rd = 1'b0;
    @(negedge clk);
    exc_overflow = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      exc_overflow = 1'b0;
      mem_data = 8'(8'h40 + cyc);
      #1;
      if (w1_mem_rd === 1'b1) rd1++;
      if (mem_rd === 1'b1) rd2++;
      if (w15_mem_rd === 1'b1) rd15++;
      if (w1_pc_wr === 1'b1 && pc1 == 0) pc1 = cyc;
      if (pc_wr === 1'b1 && pc2 == 0) pc2 = cyc;
      if (w15_pc_wr === 1'b1 && pc15 == 0) pc15 = cyc;
    end
    checks++;
    if (rd1 != 1 || rd2 != 2 || rd15 != 15) begin
      errors++;
      $display("FAIL sweep_mem_rd_len: got %0d/%0d/%0d expected 1/2/15", rd1, rd2, rd15);
    end
    checks++;
    if (w1_handler_pc !== 32'h42 || handler_pc !== 32'h43 || w15_handler_pc !== 32'h50) begin
      errors++;
      $display("FAIL sweep_capture: got %h/%h/%h expected 00000042/00000043/00000050",
               w1_handler_pc, handler_pc, w15_handler_pc);
    end
    checks++;
    if (pc1 != 3 || pc2 != 4 || pc15 != 17) begin
      errors++;
      $display("FAIL sweep_pc_wr_cycle: got %0d/%0d/%0d expected 3/4/17", pc1, pc2, pc15);
    end
    checks++;
    if (w15_stall !== 1'b0 || w15_cause !== 2'd2) begin
      errors++;
      $display("FAIL sweep_w15_end: got stall=%b cause=%0d expected 0/2", w15_stall, w15_cause);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_overflow();
    test_reset_mid_read();
    test_priority();
    test_nest();
    test_mem_wait_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
